// File: rtl/rr_arb32_ctrl_if.sv
// rtl/rr_arb32_ctrl_if.sv - request/grant bundle for the 32-way round-robin arbiter
interface rr_arb32_ctrl_if;
    logic [31:0] req;
    logic        done;
    logic [31:0] gnt;
    logic [4:0]  gnt_idx;
    logic        gnt_valid;
    logic        tmo;

    modport master (
        output req,
        output done,
        input  gnt,
        input  gnt_idx,
        input  gnt_valid,
        input  tmo
    );

    modport slave (
        input  req,
        input  done,
        output gnt,
        output gnt_idx,
        output gnt_valid,
        output tmo
    );
endinterface

// File: rtl/rr_arb32_ctrl.sv
// rtl/rr_arb32_ctrl.sv - 32-way round-robin arbiter with hold timeout and release bubble
module rr_arb32_ctrl #(
    parameter int MAX_HOLD = 16
) (
    input  logic          clk,
    input  logic          rst,
    rr_arb32_ctrl_if.slave bus
);
    typedef enum logic {IDLE, GRANT} state_t;

    localparam bit         TMO_EN    = (MAX_HOLD != 0);
    localparam logic [7:0] HOLD_LAST = (MAX_HOLD == 0) ? 8'd0 : 8'(MAX_HOLD - 1);

    state_t      state, state_n;
    logic [4:0]  ptr, ptr_n;
    logic [7:0]  hold_cnt, hold_n;
    logic [4:0]  idx_q, idx_n;
    logic        valid_q, valid_n;
    logic        tmo_q, tmo_n;
    logic [31:0] gnt_q;

    logic [4:0]  sel;
    logic [4:0]  cand;
    logic        found;
    logic        timeout_hit;
    logic        release_now;

    // Rotating priority search starting at ptr; 5-bit addition wraps modulo 32.
    always_comb begin
        sel   = 5'd0;
        cand  = 5'd0;
        found = 1'b0;
        for (int k = 0; k < 32; k++) begin
            cand = ptr + 5'(k);
            if (!found && bus.req[cand]) begin
                sel   = cand;
                found = 1'b1;
            end
        end
    end

    assign timeout_hit = TMO_EN && (hold_cnt == HOLD_LAST);
    assign release_now = bus.done || !bus.req[idx_q] || timeout_hit;

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        hold_n  = hold_cnt;
        idx_n   = idx_q;
        valid_n = valid_q;
        tmo_n   = 1'b0;
        case (state)
            IDLE: begin
                valid_n = 1'b0;
                if (found) begin
                    state_n = GRANT;
                    idx_n   = sel;
                    valid_n = 1'b1;
                    hold_n  = 8'd0;
                end
            end
            GRANT: begin
                hold_n = (hold_cnt == 8'hFF) ? 8'hFF : hold_cnt + 8'd1;
                if (release_now) begin
                    state_n = IDLE;
                    valid_n = 1'b0;
                    ptr_n   = idx_q + 5'd1;
                    // Timeout is only reported when nothing else would have ended the grant.
                    tmo_n   = timeout_hit && !bus.done && bus.req[idx_q];
                end
            end
            default: begin
                state_n = IDLE;
                valid_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= 5'd0;
            hold_cnt <= 8'd0;
            idx_q    <= 5'd0;
            valid_q  <= 1'b0;
            tmo_q    <= 1'b0;
            gnt_q    <= 32'd0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            hold_cnt <= hold_n;
            idx_q    <= idx_n;
            valid_q  <= valid_n;
            tmo_q    <= tmo_n;
            gnt_q    <= valid_n ? (32'd1 << idx_n) : 32'd0;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_idx   = idx_q;
    assign bus.gnt_valid = valid_q;
    assign bus.tmo       = tmo_q;
endmodule

// File: doc/rr_arb32_ctrl.md
RR_ARB32_CTRL -- requirements
Module: rr_arb32_ctrl

Interface
- REQ-001: Parameter MAX_HOLD, default 16, is the maximum number of consecutive cycles one grant is held; legal range 0..255; 0 disables the timeout.
- REQ-002: Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
- REQ-003: Port rst, input, 1 bit: reset, synchronous, active-high.
- REQ-004: Port req, input, 32 bits: level request, bit i = requester i.
- REQ-005: Port done, input, 1 bit: the current grantee releases the resource; ignored while no grant is active.
- REQ-006: Port gnt, output, 32 bits: one-hot grant vector, registered.
- REQ-007: Port gnt_idx, output, 5 bits: binary index of the current grantee, registered.
- REQ-008: Port gnt_valid, output, 1 bit: a grant is active.
- REQ-009: Port tmo, output, 1 bit: one-cycle pulse when a grant ends by timeout.

Function
- REQ-010: The controller shall have two states, IDLE and GRANT, plus internal registers ptr[4:0] (search start) and hold_cnt[7:0].
- REQ-011: gnt shall equal (1 << gnt_idx) while gnt_valid=1, and shall be 32'h0 while gnt_valid=0; one-hot invariant at all times.
- REQ-012: In IDLE with req != 0, the controller shall select the first set bit of req searching ptr, ptr+1, ... 31, 0, ... ptr-1 (modulo 32).
- REQ-013: On that edge the controller shall enter GRANT, load gnt_idx with the selection, set gnt_valid=1 and clear hold_cnt; grant latency is one edge after req is sampled.
- REQ-014: In IDLE with req == 0, outputs and ptr shall hold, with gnt_valid=0.
- REQ-015: In GRANT, hold_cnt shall increment by 1 each cycle (saturating at 255).
- REQ-016: In GRANT, a release shall occur at the edge where any one of these holds:
  - done=1;
  - req[gnt_idx]=0;
  - MAX_HOLD != 0 and hold_cnt == MAX_HOLD-1.
- REQ-017: gnt_valid shall therefore be high for at most MAX_HOLD consecutive cycles.
- REQ-018: On release, the controller shall:
  - return to IDLE;
  - set gnt_valid=0 (gnt=0);
  - set ptr = gnt_idx+1 modulo 32 (31 wraps to 0);
  - keep gnt_idx at its last value.
- REQ-019: Every release shall be followed by exactly one IDLE cycle (bubble); back-to-back grants are separated by one cycle with gnt_valid=0.
- REQ-020: tmo shall pulse high for one cycle, coincident with the first IDLE cycle, only when the timeout condition caused the release and done=0 and req[gnt_idx]=1 on that edge.
- REQ-021: When done or a request drop coincides with timeout, the release shall be counted as normal and tmo shall stay 0.
- REQ-022: A single persistent requester shall be re-granted after the bubble, because the modulo search wraps back to it.
- REQ-023: Changes to req bits other than req[gnt_idx] during GRANT shall not affect the current grant.
- REQ-024: No combinational path shall exist from inputs to outputs.

Reset
- REQ-025: While rst=1 at a rising edge, the controller shall enter IDLE and set gnt=0, gnt_idx=0, gnt_valid=0, tmo=0, ptr=0, hold_cnt=0.
- REQ-026: Reset shall override any in-progress grant, including one where done is asserted in the same cycle.
- REQ-027: On the first edge after rst deasserts, the controller shall arbitrate normally from ptr=0.

Verification
- REQ-028: Reset with req=0 -> gnt=0, gnt_idx=0, gnt_valid=0, tmo=0, stable for 10 cycles.
- REQ-029: req=32'h0000_0005, pulse done during first grant -> gnt=32'h1 (idx 0); one bubble cycle; then gnt=32'h4 (idx 2).
- REQ-030: ptr driven to 31, req[31] and req[0] held, done pulsed each grant -> grant order 31, 0, 31 with idx wrap 31->0.
- REQ-031: MAX_HOLD=4, req=32'h80 held, done=0 -> gnt=32'h80 for exactly 4 cycles; tmo=1 for one cycle; re-grant of idx 7 after the bubble.
- REQ-032: MAX_HOLD=4, done=1 on the 4th grant cycle -> release with tmo=0.
- REQ-033: req[3] granted, then req[3] dropped with done=0 -> gnt_valid=0 at the next edge, tmo=0, ptr=4.
- REQ-034: rst asserted mid-grant at idx 9 -> next cycle all outputs 0; after rst low with req=32'h200, grant idx 9 from ptr=0.
